wb_echo_master: RTL and testbench

Parametrised Wishbone pipelined-mode master that moves words from a receive peripheral back to a transmit peripheral through an internal FIFO. It issues a read to RD_ADR when the peripheral raises its receive interrupt, buffers the returned data, and writes buffered words to WR_ADR. Compared with a strict one-read/one-write alternation, it supports bursts of up to DEPTH received words, separate read/write addresses, an ack timeout and error reporting. It sits at top level in place of the fixed echo state machine, in front of wb_uart or any peripheral with the same interface.

---
 rtl/wb_echo_master.sv | 204 ++++++++++++++++++++
 tb/tb_wb_echo_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_echo_master.sv
// wb_echo_master: Wishbone pipelined-mode master that reads words from a
// receive peripheral into a small FIFO and writes them back out to a
// transmit address. Reads take priority over writes, a transfer that is
// never acknowledged is aborted after TIMEOUT wait cycles and reported
// through a sticky error flag and a saturating error counter.
//
// Handshake: a request is presented with cyc=1/stb=1 and is taken by the
// slave on the first rising edge where wb_stall_i=0; after that stb drops
// and cyc stays high until the edge where wb_ack_i=1 (or the timeout),
// which completes the transfer. An ack on the accepting edge completes the
// transfer immediately. Acks seen while no transfer is open are ignored.
module wb_echo_master #(
  parameter int             DW      = 32,
  parameter int             AW      = 4,
  parameter int             DEPTH   = 8,
  parameter logic [AW-1:0]  RD_ADR  = '0,
  parameter logic [AW-1:0]  WR_ADR  = '0,
  parameter int             TIMEOUT = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [AW-1:0]              wb_adr_o,
  output logic [DW-1:0]              wb_dat_o,
  input  logic [DW-1:0]              wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_stall_i,
  input  logic                       int_rx_i,
  input  logic                       clr_err_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       err_o,
  output logic [7:0]                 err_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  // Wait counter runs 0..TIMEOUT-1, so it needs at least one bit.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LFULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmo_cnt;

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic            fifo_full;
  logic            fifo_empty;
  logic            want_read;
  logic            want_write;
  logic            xfer_ack;
  logic            xfer_tmo;
  logic            push;
  logic            pop;

  // FIFO status straight from the occupancy counter.
  assign fifo_full  = (level_o == LFULL);
  assign fifo_empty = (level_o == '0);

  // IDLE decision: a pending receive wins unless there is no room for it.
  assign want_read  = int_rx_i && !fifo_full;
  assign want_write = !fifo_empty;

  // Completion events for the single outstanding transfer. An ack is only
  // honoured in REQ on the accepting edge (stall low) or while waiting.
  assign xfer_ack = ((state == S_REQ) && !wb_stall_i && wb_ack_i) ||
                    ((state == S_WAIT_ACK) && wb_ack_i);
  assign xfer_tmo = (state == S_WAIT_ACK) && !wb_ack_i && (tmo_cnt == TLAST);

  // A completed read stores its data; a write leaves the FIFO whether it
  // was acknowledged or abandoned, so a timed-out word is dropped.
  assign push = xfer_ack && !wb_we_o;
  assign pop  = (xfer_ack || xfer_tmo) && wb_we_o;

  // Transfer sequencer: picks the next transfer in IDLE and owns all bus outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= S_IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (want_read) begin
            state    <= S_REQ;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= RD_ADR;
            wb_dat_o <= '0;
          end else if (want_write) begin
            state    <= S_REQ;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= WR_ADR;
            wb_dat_o <= mem[rd_ptr];
          end
        end

        S_REQ: begin
          // Stall cycles simply hold the request; they do not count toward timeout.
          if (!wb_stall_i) begin
            if (wb_ack_i) begin
              state    <= S_IDLE;
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              wb_we_o  <= 1'b0;
              wb_adr_o <= '0;
              wb_dat_o <= '0;
            end else begin
              state    <= S_WAIT_ACK;
              wb_stb_o <= 1'b0;
              tmo_cnt  <= '0;
            end
          end
        end

        S_WAIT_ACK: begin
          if (wb_ack_i || xfer_tmo) begin
            state    <= S_IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_adr_o <= '0;
          wb_dat_o <= '0;
        end
      endcase
    end
  end

  // FIFO storage; only written on a read ack, so it needs no reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wb_dat_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        level_o <= level_o + LW'(1);
      end else if (pop && !push) begin
        level_o <= level_o - LW'(1);
      end
    end
  end

  // Error reporting: a timeout on the same edge as a clear still registers as one error.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else if (xfer_tmo) begin
      err_o <= 1'b1;
      if (clr_err_i) begin
        err_cnt_o <= 8'd1;
      end else if (err_cnt_o != 8'hFF) begin
        err_cnt_o <= err_cnt_o + 8'd1;
      end
    end else if (clr_err_i) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end
  end

endmodule

// File: tb/tb_wb_echo_master.sv
// tb_wb_echo_master: drives wb_echo_master with a behavioural Wishbone slave
// and receive peripheral, and checks the bus, FIFO level and error outputs
// against a queue-based model of the echo behaviour.
module tb_wb_echo_master;

  localparam int            DW      = 32;
  localparam int            AW      = 4;
  localparam int            DEPTH   = 8;
  localparam int            TIMEOUT = 4;
  localparam logic [AW-1:0] RD_ADR  = 4'h3;
  localparam logic [AW-1:0] WR_ADR  = 4'hC;
  localparam int            LW      = $clog2(DEPTH+1);

  // ---------------- clock / reset ----------------
  logic          wb_clk_i  = 1'b0;
  logic          wb_rst_ni = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_ack_i, wb_stall_i, int_rx_i, clr_err_i;
  logic [LW-1:0] level_o;
  logic          err_o;
  logic [7:0]    err_cnt_o;

  wb_echo_master #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH),
    .RD_ADR(RD_ADR), .WR_ADR(WR_ADR), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_stall_i (wb_stall_i),
    .int_rx_i   (int_rx_i),
    .clr_err_i  (clr_err_i),
    .level_o    (level_o),
    .err_o      (err_o),
    .err_cnt_o  (err_cnt_o)
  );

  // ---------------- reference model state ----------------
  logic [DW-1:0] exp_q[$];   // words that must appear on the write side, in order
  logic [DW-1:0] rx_q[$];    // words the receive peripheral still holds
  int            lvl_m;      // expected occupancy after the next edge
  logic          err_m;
  logic [7:0]    errcnt_m;
  logic          exp_end;    // next edge completes or aborts the open transfer
  logic          wait_expired;
  logic          end_req, end_done;

  // slave knobs
  int stall_min, stall_max, ack_min, ack_max, clr_pct;
  bit never_wr, spur_en, clr_on_to, force_clr;

  // slave view of the open transfer
  bit in_xfer, x_we;
  int x_stall, x_delay, x_k;

  // ---------------- driver tasks ----------------
  // One slave/peripheral step, called at each falling edge for the next rising edge.
  task automatic drive_cycle();
    bit done, tmo;
    logic [DW-1:0] d;
    done = 0;
    tmo  = 0;
    wb_ack_i   = 1'b0;
    wb_stall_i = 1'b0;
    wb_dat_i   = $urandom;
    exp_end    = 1'b0;
    clr_err_i  = force_clr || ($urandom_range(0, 99) < clr_pct);
    if (wb_cyc_o && wb_stb_o) begin
      if (!in_xfer) begin
        in_xfer = 1;
        x_we    = wb_we_o;
        x_stall = $urandom_range(stall_min, stall_max);
        x_delay = $urandom_range(ack_min, ack_max);
        x_k     = 0;
      end
      if (x_stall > 0) begin
        wb_stall_i = 1'b1;
        x_stall--;
      end else if (x_delay == 0 && !(never_wr && x_we)) begin
        done = 1;
      end
    end else if (wb_cyc_o && in_xfer) begin
      x_k++;
      if (x_k == x_delay && !(never_wr && x_we)) done = 1;
      else if (x_k == TIMEOUT) tmo = 1;
    end else if (!wb_cyc_o && spur_en && $urandom_range(0, 3) == 0) begin
      wb_ack_i = 1'b1;
    end

    if (done) begin
      wb_ack_i = 1'b1;
      if (!x_we) begin
        d = (rx_q.size() > 0) ? rx_q.pop_front() : $urandom;
        wb_dat_i = d;
        exp_q.push_back(d);
        lvl_m++;
      end else begin
        lvl_m--;
      end
    end
    if (tmo) begin
      if (x_we) lvl_m--;
      if (clr_on_to) clr_err_i = 1'b1;
    end
    if (done || tmo) begin
      exp_end = 1'b1;
      in_xfer = 0;
    end
    if (tmo) begin
      err_m    = 1'b1;
      errcnt_m = clr_err_i ? 8'd1 : ((errcnt_m == 8'hFF) ? 8'hFF : errcnt_m + 8'd1);
    end else if (clr_err_i) begin
      err_m    = 1'b0;
      errcnt_m = 8'd0;
    end
    int_rx_i = (rx_q.size() > 0);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge wb_clk_i);
      drive_cycle();
    end
  endtask

  // Runs until the peripheral, FIFO and bus are all idle, within a cycle budget.
  task automatic run_quiet(input int budget);
    int n;
    bit quiet;
    n = 0;
    quiet = 0;
    while (!quiet && n < budget) begin
      @(negedge wb_clk_i);
      drive_cycle();
      n++;
      quiet = (rx_q.size() == 0) && (lvl_m == 0) && !in_xfer && !wb_cyc_o;
    end
    if (!quiet) wait_expired = 1'b1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    logic          p_valid, p_cyc, p_stb, p_we;
    logic [AW-1:0] p_adr;
    logic [DW-1:0] p_dat;
    int            p_lvl;
    logic          e_irq, e_end, e_stall, exp_rd, exp_req;
    logic [DW-1:0] w;
    p_valid = 0; p_cyc = 0; p_stb = 0; p_we = 0; p_adr = '0; p_dat = '0; p_lvl = 0;
    end_done = 0;
    forever begin
      @(posedge wb_clk_i or negedge wb_rst_ni);
      if (!wb_rst_ni) begin
        #1;
        chk("rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        chk("rst_level", 64'(level_o), 64'(0));
        chk("rst_err", 64'({err_o, err_cnt_o}), 64'(0));
        chk("rst_bus", 64'({wb_we_o, wb_adr_o, wb_dat_o}), 64'(0));
        p_valid = 0;
      end else begin
        e_irq   = int_rx_i;
        e_end   = exp_end;
        e_stall = wb_stall_i;
        #3;
        chk("level", 64'(level_o), 64'(lvl_m));
        chk("err", 64'(err_o), 64'(err_m));
        chk("err_cnt", 64'(err_cnt_o), 64'(errcnt_m));
        chk("wait_bound", 64'(wait_expired), 64'(0));
        if (e_end) chk("end_cyc", 64'(wb_cyc_o), 64'(0));
        if (!wb_cyc_o) chk("idle_bus", 64'({wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 64'(0));
        if (p_valid && !p_cyc) begin
          exp_rd  = e_irq && (p_lvl < DEPTH);
          exp_req = exp_rd || (p_lvl > 0);
          chk("decide", 64'({wb_cyc_o, wb_stb_o}), exp_req ? 64'(3) : 64'(0));
          if (exp_req && wb_stb_o) begin
            chk("dir", 64'(wb_we_o), 64'(!exp_rd));
            if (wb_we_o) begin
              chk("wr_adr", 64'(wb_adr_o), 64'(WR_ADR));
              chk("wr_avail", 64'(exp_q.size() > 0), 64'(1));
              if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("wr_data", 64'(wb_dat_o), 64'(w));
              end
            end else begin
              chk("rd_adr", 64'(wb_adr_o), 64'(RD_ADR));
            end
          end
        end
        if (p_valid && p_stb && !e_end) begin
          chk(e_stall ? "stall_hold" : "to_wait", 64'({wb_cyc_o, wb_stb_o}), e_stall ? 64'(3) : 64'(2));
        end
        if (p_valid && p_cyc && wb_cyc_o) begin
          if (!p_stb) chk("wait_stb", 64'(wb_stb_o), 64'(0));
          chk("hold", 64'({wb_we_o, wb_adr_o, wb_dat_o}), 64'({p_we, p_adr, p_dat}));
        end
        if (end_req && !end_done) begin
          chk("drain", 64'(exp_q.size()), 64'(0));
          end_done = 1;
        end
        p_valid = 1;
        p_cyc = wb_cyc_o; p_stb = wb_stb_o; p_we = wb_we_o;
        p_adr = wb_adr_o; p_dat = wb_dat_o; p_lvl = lvl_m;
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin : main
    bit found;
    wb_ack_i = 0; wb_stall_i = 0; wb_dat_i = '0; int_rx_i = 0; clr_err_i = 0;
    lvl_m = 0; err_m = 0; errcnt_m = 0; exp_end = 0; wait_expired = 0; end_req = 0;
    stall_min = 0; stall_max = 0; ack_min = 1; ack_max = 1; clr_pct = 0;
    never_wr = 0; spur_en = 0; clr_on_to = 0; force_clr = 0;
    in_xfer = 0; x_we = 0; x_stall = 0; x_delay = 0; x_k = 0;

    run(3);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;

    // echo of a single word, ack one cycle after the strobe
    rx_q.push_back(32'h0000_00A5);
    run_quiet(40);

    // burst of ten words into an eight-deep FIFO, slow write acks
    for (int i = 1; i <= 10; i++) rx_q.push_back(DW'(i));
    ack_min = 1; ack_max = 3;
    run_quiet(300);

    // long stall in REQ must not count toward the timeout
    stall_min = 5; stall_max = 5; ack_min = 1; ack_max = 1;
    rx_q.push_back(32'h5A5A_0001);
    run_quiet(60);
    stall_min = 0; stall_max = 0;

    // two unacknowledged writes, then a timeout coinciding with a clear
    never_wr = 1;
    rx_q.push_back(32'h0000_0033);
    run_quiet(60);
    rx_q.push_back(32'h0000_0034);
    run_quiet(60);
    clr_on_to = 1;
    rx_q.push_back(32'h0000_0044);
    run_quiet(60);
    clr_on_to = 0;
    never_wr = 0;
    force_clr = 1;
    run(1);
    force_clr = 0;
    run(3);

    // randomized traffic: stalls, ack delays, lost writes, stray acks, clears
    stall_max = 2; ack_min = 0; ack_max = 3; spur_en = 1; clr_pct = 3;
    for (int i = 0; i < 800; i++) begin
      if (i % 60 == 0) never_wr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0 && rx_q.size() < 6) rx_q.push_back($urandom);
      run(1);
    end
    never_wr = 0; spur_en = 0; clr_pct = 0; stall_max = 0; ack_min = 1; ack_max = 1;
    run_quiet(300);

    // asynchronous reset while a write waits for its ack with three words queued
    never_wr = 1;
    for (int i = 0; i < 3; i++) rx_q.push_back($urandom);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge wb_clk_i);
      if (wb_cyc_o && !wb_stb_o && wb_we_o) found = 1;
      else drive_cycle();
    end
    if (!found) wait_expired = 1'b1;
    #2;
    wb_rst_ni = 1'b0;
    rx_q.delete(); exp_q.delete();
    lvl_m = 0; err_m = 0; errcnt_m = 0; exp_end = 0; in_xfer = 0; never_wr = 0;
    wb_ack_i = 0; wb_stall_i = 0; int_rx_i = 0; clr_err_i = 0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    wb_ack_i  = 1'b1;
    wb_dat_i  = 32'hDEAD_BEEF;
    @(negedge wb_clk_i);
    wb_ack_i  = 1'b0;
    run(4);

    // one more echo after the reset, then drain and report
    rx_q.push_back(32'h0BAD_F00D);
    run_quiet(60);
    end_req = 1;
    for (int i = 0; i < 10 && !end_done; i++) run(1);
    run(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
